integration_sequencer: RTL and testbench
========================================

// Module: integration_sequencer
// PURPOSE
//  Sequences the correlator datapath: times integration windows, issues snapshot/clear strobes to the
//  pulse/correlation counters, then streams the snapshot word-by-word to the UART word transmitter
//  with a framed header. Sits between the counter bank (snapshot buffer) and the TX serializer.
// PARAMETERS
//  RESOLUTION   16    width of one counter word / TX word (bits)
//  NUM_WORDS    1436  data words per frame (NUM_CORRELATORS*DELAY_LINES+NUM_INPUTS = 28*51+8)
//  IDX_W        11    width of word_idx_o; must satisfy 2**IDX_W >= NUM_WORDS
//  MIN_PERIOD   16    smallest legal integration period in clk cycles
//  SYNC_WORD    16'hA55A  first header word of every frame
// PORTS
//  clk          in   1           correlator clock
//  reset_n      in   1           asynchronous active-low reset
//  enable_i     in   1           1 = run integration/readout cycle; 0 = stop after current frame
//  period_i     in   32          integration window length in clk cycles
//  snap_o       out  1           1-cycle strobe: counters copy into snapshot buffer
//  clear_o      out  1           1-cycle strobe, cycle after snap_o: counters zeroed
//  word_idx_o   out  IDX_W       snapshot word select to external mux
//  data_i       in   RESOLUTION  snapshot word addressed by word_idx_o, valid 1 cycle after index change
//  tx_data_o    out  RESOLUTION  word to serializer
//  tx_valid_o   out  1           tx_data_o valid
//  tx_ready_i   in   1           serializer accepts word when tx_valid_o & tx_ready_i at posedge clk
//  busy_o       out  1           1 while a frame is being streamed
//  overrun_o    out  1           sticky; set on first dropped frame, cleared only by reset
// BEHAVIOUR
//  Reset: all outputs 0; FSM=IDLE; window counter, word index, frame seq, overrun count = 0.
//  States: IDLE -> INTEGRATE (enable_i=1) -> SNAP (1 cyc) -> CLEAR (1 cyc) -> HDR0 -> HDR1 -> DATA -> [TRL]
//   -> INTEGRATE or IDLE.
//  Window timer independent of readout: loads eff_period = max(period_i, MIN_PERIOD) at window start;
//   window ends when count reaches eff_period-1; next window starts next cycle (no gap). period_i
//   changes take effect at the next window start.
//  Window end with readout idle: snap_o=1 that cycle, clear_o=1 next cycle; frame starts cycle after clear_o.
//  Window end while busy_o=1 (overrun): no snap_o, clear_o still pulses (counts discarded), overrun_cnt
//   +1 saturating at 8'hFF, overrun_o set; frame in progress unaffected.
//  Frame: HDR0 = SYNC_WORD; HDR1 = {frame_seq[7:0], overrun_cnt[7:0]} (zero-extended/truncated to
//   RESOLUTION); then words 0..NUM_WORDS-1 of data_i in index order. frame_seq +1 (mod 256) per completed frame.
//  Handshake: each data word = fetch cycle (word_idx_o updated, tx_valid_o=0) then tx_valid_o=1 holding
//   tx_data_o stable until accepted. Header words need no fetch cycle. tx_valid_o never drops without accept.
//  Last word accepted: busy_o falls same edge; word_idx_o returns to 0.
//  enable_i=0: no new windows start; in-flight frame completes; a pending window in INTEGRATE is
//   abandoned (no snap). enable_i re-asserted: fresh window from count 0.
//  busy_o=1 from HDR0 entry through final accept. snap_o and clear_o never both high.
//  reset_n low mid-frame: immediate abort, outputs to reset values; no partial-frame completion.
// CONFIGURATION
//  CHECKSUM_EN defined: trailer word TRL after last data word = RESOLUTION-bit wrap-around sum of HDR1
//   and all data words; busy_o covers TRL. Frame = NUM_WORDS+3 words.
//  CHECKSUM_EN undefined: no trailer; frame = NUM_WORDS+2 words; no adder logic.
// TESTING
//  T1 reset: reset_n=0 mid-DATA -> all outputs 0 at once; after release with enable_i=0 stays IDLE, no strobes.
//  T2 basic frame: NUM_WORDS=4, period_i=100, tx_ready_i=1, data_i=idx+16'h100 -> snap_o at cycle 99,
//   clear_o 100, words A55A,0000,0100,0101,0102,0103; second frame HDR1=0x0100.
//  T3 backpressure: tx_ready_i toggled random -> tx_data_o stable while valid & !ready; no word lost/duplicated.
//  T4 overrun: period_i=20 (<frame time), tx_ready_i low 50 cycles -> clear_o pulses without snap_o,
//   overrun_o=1, next HDR1 low byte = number of skipped windows.
//  T5 clamp/disable: period_i=3 -> window 16 cycles; drop enable_i mid-frame -> frame finishes, then IDLE.
//  T6 CHECKSUM_EN: data all 16'hFFFF, NUM_WORDS=4, seq=0 -> trailer 16'hFFFC; without macro no trailer.

Source files
------------

// File: rtl/integration_sequencer.sv
// integration_sequencer: times integration windows, strobes snapshot/clear to the counter bank and
// streams a framed snapshot to the TX serializer. Define CHECKSUM_EN to append a checksum trailer.
module integration_sequencer #(
    parameter int          RESOLUTION = 16,
    parameter int          NUM_WORDS  = 1436,
    parameter int          IDX_W      = 11,
    parameter int          MIN_PERIOD = 16,
    parameter logic [15:0] SYNC_WORD  = 16'hA55A
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  enable_i,
    input  logic [31:0]           period_i,
    output logic                  snap_o,
    output logic                  clear_o,
    output logic [IDX_W-1:0]      word_idx_o,
    input  logic [RESOLUTION-1:0] data_i,
    output logic [RESOLUTION-1:0] tx_data_o,
    output logic                  tx_valid_o,
    input  logic                  tx_ready_i,
    output logic                  busy_o,
    output logic                  overrun_o,
    output logic [3:0]            state_o
);

    typedef enum logic [3:0] {
        S_IDLE      = 4'd0,
        S_INTEGRATE = 4'd1,
        S_SNAP      = 4'd2,
        S_CLEAR     = 4'd3,
        S_HDR0      = 4'd4,
        S_HDR1      = 4'd5,
        S_FETCH     = 4'd6,
        S_DATA      = 4'd7,
        S_TRL       = 4'd8
    } state_t;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);

    state_t                  state_q, state_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [RESOLUTION-1:0]   tx_data_q, tx_data_d;
    logic [7:0]              seq_q, seq_d;
    logic [7:0]              ovr_cnt_q, ovr_cnt_d;
    logic                    overrun_q, overrun_d;
    logic                    ovr_clear_q, ovr_clear_d;
    logic                    win_run_q, win_run_d;
    logic [31:0]             win_cnt_q, win_cnt_d;
    logic [31:0]             win_len_q, win_len_d;

    logic [31:0]             eff_period;
    logic                    win_end;
    logic                    win_pre;
    logic                    ovr_event;
    logic                    accept;
    logic                    frame_end;
    logic [15:0]             hdr1_raw;
    logic [RESOLUTION-1:0]   hdr1_word;

    // Valid/ready: a word moves when tx_valid_o & tx_ready_i at posedge clk; once raised, tx_valid_o
    // and tx_data_o hold until that happens.
    assign accept     = tx_valid_o & tx_ready_i;
    assign eff_period = (period_i < 32'(MIN_PERIOD)) ? 32'(MIN_PERIOD) : period_i;
    assign win_end    = win_run_q && (win_cnt_q == win_len_q - 32'd1);
    // Look-ahead so the SNAP state coincides exactly with the last window cycle.
    assign win_pre    = win_run_q && enable_i && (win_cnt_q == win_len_q - 32'd2);
    assign hdr1_raw   = {seq_q, ovr_cnt_q};
    assign hdr1_word  = RESOLUTION'(hdr1_raw);

    always_comb begin
        win_run_d = win_run_q;
        win_cnt_d = win_cnt_q;
        win_len_d = win_len_q;
        if (!enable_i) begin
            win_run_d = 1'b0;
        end else if (!win_run_q || win_end) begin
            win_run_d = 1'b1;
            win_cnt_d = 32'd0;
            win_len_d = eff_period;
        end else begin
            win_cnt_d = win_cnt_q + 32'd1;
        end
    end

    always_comb begin
        ovr_event   = win_end && busy_o;
        ovr_clear_d = ovr_event;
        overrun_d   = overrun_q | ovr_event;
        ovr_cnt_d   = (ovr_event && (ovr_cnt_q != 8'hFF)) ? ovr_cnt_q + 8'd1 : ovr_cnt_q;
    end

`ifdef CHECKSUM_EN
    logic [RESOLUTION-1:0] sum_q, sum_d;

    always_comb begin
        sum_d = sum_q;
        if (state_q == S_HDR0 && accept) begin
            sum_d = hdr1_word;
        end else if (state_q == S_FETCH) begin
            sum_d = sum_q + data_i;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sum_q <= '0;
        end else begin
            sum_q <= sum_d;
        end
    end
`endif

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        tx_data_d = tx_data_q;
        seq_d     = seq_q;
        frame_end = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (enable_i) state_d = S_INTEGRATE;
            end
            S_INTEGRATE: begin
                if (!enable_i) state_d = S_IDLE;
                else if (win_pre) state_d = S_SNAP;
            end
            S_SNAP: state_d = S_CLEAR;
            S_CLEAR: begin
                state_d   = S_HDR0;
                tx_data_d = RESOLUTION'(SYNC_WORD);
            end
            S_HDR0: begin
                if (accept) begin
                    state_d   = S_HDR1;
                    tx_data_d = hdr1_word;
                end
            end
            S_HDR1: begin
                if (accept) state_d = S_FETCH;
            end
            // data_i answers the index set on entry here by the closing edge of this cycle.
            S_FETCH: begin
                state_d   = S_DATA;
                tx_data_d = data_i;
            end
            S_DATA: begin
                if (accept) begin
                    if (idx_q == LAST_IDX) begin
`ifdef CHECKSUM_EN
                        state_d   = S_TRL;
                        tx_data_d = sum_q;
`else
                        frame_end = 1'b1;
`endif
                    end else begin
                        idx_d   = idx_q + IDX_W'(1);
                        state_d = S_FETCH;
                    end
                end
            end
`ifdef CHECKSUM_EN
            S_TRL: begin
                if (accept) frame_end = 1'b1;
            end
`endif
            default: state_d = S_IDLE;
        endcase
        if (frame_end) begin
            idx_d = '0;
            seq_d = seq_q + 8'd1;
            if (!enable_i) state_d = S_IDLE;
            else if (win_pre) state_d = S_SNAP;
            else state_d = S_INTEGRATE;
        end
    end

    always_comb begin
        snap_o     = (state_q == S_SNAP);
        clear_o    = (state_q == S_CLEAR) || ovr_clear_q;
        tx_valid_o = (state_q == S_HDR0) || (state_q == S_HDR1) ||
                     (state_q == S_DATA) || (state_q == S_TRL);
        busy_o     = tx_valid_o || (state_q == S_FETCH);
        word_idx_o = idx_q;
        tx_data_o  = tx_data_q;
        overrun_o  = overrun_q;
        state_o    = state_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            idx_q       <= '0;
            tx_data_q   <= '0;
            seq_q       <= 8'd0;
            ovr_cnt_q   <= 8'd0;
            overrun_q   <= 1'b0;
            ovr_clear_q <= 1'b0;
            win_run_q   <= 1'b0;
            win_cnt_q   <= 32'd0;
            win_len_q   <= 32'(MIN_PERIOD);
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            tx_data_q   <= tx_data_d;
            seq_q       <= seq_d;
            ovr_cnt_q   <= ovr_cnt_d;
            overrun_q   <= overrun_d;
            ovr_clear_q <= ovr_clear_d;
            win_run_q   <= win_run_d;
            win_cnt_q   <= win_cnt_d;
            win_len_q   <= win_len_d;
        end
    end

endmodule

// File: tb/tb_integration_sequencer.sv
// Bench for integration_sequencer: window-timing vector table, scoreboard of streamed frame words,
// and hand-written reset / overrun / backpressure / disable sequences.
module tb_integration_sequencer;
  localparam int RES   = 16;
  localparam int NW    = 4;
  localparam int IW    = 2;
  localparam logic [3:0] ST_IDLE = 4'd0;
  localparam logic [3:0] ST_DATA = 4'd7;

  logic            clk = 1'b0;
  logic            reset_n = 1'b0;
  logic            enable_i = 1'b0;
  logic [31:0]     period_i = 32'd100;
  logic            snap_o, clear_o, tx_valid_o, busy_o, overrun_o;
  logic [IW-1:0]   word_idx_o;
  logic [RES-1:0]  data_i, tx_data_o;
  logic            tx_ready_i = 1'b1;
  logic [3:0]      state_o;

  int errors = 0;
  int checks = 0;
  int data_mode = 0;   // 0: idx+0x100, 1: all ones
  int ready_mode = 0;  // 0: always ready, 1: random, 2: driven by test
  int seq_m = 0;
  int exp_ovr = 0;
  int ovr_clr_seen = 0;
  logic [RES-1:0] exp_q[$];

  integration_sequencer #(.RESOLUTION(RES), .NUM_WORDS(NW), .IDX_W(IW), .MIN_PERIOD(16)) dut (
    .clk(clk), .reset_n(reset_n), .enable_i(enable_i), .period_i(period_i),
    .snap_o(snap_o), .clear_o(clear_o), .word_idx_o(word_idx_o), .data_i(data_i),
    .tx_data_o(tx_data_o), .tx_valid_o(tx_valid_o), .tx_ready_i(tx_ready_i),
    .busy_o(busy_o), .overrun_o(overrun_o), .state_o(state_o)
  );

  // Clock / snapshot-buffer model
  always #5 clk = ~clk;
  assign data_i = (data_mode == 1) ? 16'hFFFF : 16'(word_idx_o) + 16'h0100;

  function automatic logic [RES-1:0] exp_word(input int k);
    return (data_mode == 1) ? 16'hFFFF : 16'(k) + 16'h0100;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_frame();
    logic [RES-1:0] sum;
    logic [RES-1:0] hdr;
    hdr = {8'(seq_m), 8'(exp_ovr)};
    exp_q.push_back(16'hA55A);
    exp_q.push_back(hdr);
    sum = hdr;
    for (int k = 0; k < NW; k++) begin
      exp_q.push_back(exp_word(k));
      sum = sum + exp_word(k);
    end
`ifdef CHECKSUM_EN
    exp_q.push_back(sum);
`endif
    seq_m = (seq_m + 1) % 256;
  endtask

  // Ready driver
  initial begin
    forever begin
      @(negedge clk);
      if (ready_mode == 0) tx_ready_i = 1'b1;
      else if (ready_mode == 1) tx_ready_i = 1'($urandom_range(0, 1));
    end
  end

  // Scoreboard monitor: samples just after the falling edge
  initial begin
    logic prev_valid, prev_ready, prev_snap;
    logic [RES-1:0] prev_data;
    prev_valid = 1'b0; prev_ready = 1'b0; prev_snap = 1'b0; prev_data = '0;
    forever begin
      @(negedge clk);
      #1;
      if (!reset_n) begin
        prev_valid = 1'b0; prev_snap = 1'b0;
        continue;
      end
      if (snap_o && clear_o) check("snap_clear_exclusive", 32'(clear_o), 32'd0);
      if (prev_valid && !prev_ready) begin
        check("hold_valid", 32'(tx_valid_o), 32'd1);
        check("hold_data", 32'(tx_data_o), 32'(prev_data));
      end
      if (clear_o && !prev_snap) ovr_clr_seen++;
      if (snap_o) push_frame();
      if (tx_valid_o && tx_ready_i) begin
        if (exp_q.size() == 0) check("extra_word", 32'(tx_data_o), 32'hFFFF_FFFF);
        else check("tx_word", 32'(tx_data_o), 32'(exp_q.pop_front()));
      end
      prev_valid = tx_valid_o; prev_ready = tx_ready_i;
      prev_data = tx_data_o; prev_snap = snap_o;
    end
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_snap"}, 32'(snap_o), 0);
    check({tag, "_clear"}, 32'(clear_o), 0);
    check({tag, "_idx"}, 32'(word_idx_o), 0);
    check({tag, "_txdata"}, 32'(tx_data_o), 0);
    check({tag, "_valid"}, 32'(tx_valid_o), 0);
    check({tag, "_busy"}, 32'(busy_o), 0);
    check({tag, "_overrun"}, 32'(overrun_o), 0);
    check({tag, "_state"}, 32'(state_o), 32'(ST_IDLE));
  endtask

  task automatic do_reset();
    @(negedge clk);
    enable_i = 1'b0;
    reset_n = 1'b0;
    #1;
    check_reset_outputs("reset");
    repeat (3) @(negedge clk);
    exp_q.delete();
    seq_m = 0;
    exp_ovr = 0;
    reset_n = 1'b1;
  endtask

  // Returns the number of falling edges until snap_o is seen, or -1 when the budget expires.
  task automatic wait_snap(input int budget, output int n);
    n = 0;
    while (n < budget) begin
      @(negedge clk);
      n++;
      if (snap_o) return;
    end
    n = -1;
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while ((busy_o || state_o != ST_IDLE) && n < 400) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_drain_in_time"}, 32'(n < 400), 1);
    repeat (3) @(negedge clk);
    check({tag, "_queue_empty"}, 32'(exp_q.size()), 0);
  endtask

  task automatic quiet(input string tag, input int cycles);
    int hits;
    hits = 0;
    repeat (cycles) begin
      @(negedge clk);
      if (snap_o || clear_o || busy_o) hits++;
    end
    check({tag, "_quiet"}, 32'(hits), 0);
  endtask

  typedef struct {
    logic [31:0] period;
    int          mode;
    int          exp_len;
  } vec_t;

  initial begin
    vec_t vecs[6];
    int n;

    vecs[0] = '{period: 32'd100, mode: 0, exp_len: 100};
    vecs[1] = '{period: 32'd3,   mode: 1, exp_len: 16};
    vecs[2] = '{period: 32'd16,  mode: 0, exp_len: 16};
    vecs[3] = '{period: 32'd17,  mode: 1, exp_len: 17};
    vecs[4] = '{period: 32'd0,   mode: 0, exp_len: 16};
    vecs[5] = '{period: 32'd40,  mode: 1, exp_len: 40};

    // Window timing, clamp and basic frames
    for (int i = 0; i < 6; i++) begin
      do_reset();
      data_mode = vecs[i].mode;
      ready_mode = 0;
      period_i = vecs[i].period;
      enable_i = 1'b1;
      wait_snap(300, n);
      check($sformatf("v%0d_first_snap", i), 32'(n), 32'(vecs[i].exp_len));
      @(negedge clk);
      check($sformatf("v%0d_clear_after_snap", i), 32'({clear_o, snap_o}), 32'b10);
      @(negedge clk);
      check($sformatf("v%0d_hdr0_valid", i), 32'({busy_o, tx_valid_o}), 32'b11);
      wait_snap(300, n);
      check($sformatf("v%0d_second_snap", i), 32'(n), 32'(vecs[i].exp_len - 2));
      enable_i = 1'b0;
      drain($sformatf("v%0d", i));
      check($sformatf("v%0d_no_overrun", i), 32'(overrun_o), 0);
    end

    // Overrun: header stalled for 50 cycles while 20-cycle windows keep expiring
    do_reset();
    data_mode = 0;
    ready_mode = 0;
    period_i = 32'd20;
    ovr_clr_seen = 0;
    enable_i = 1'b1;
    wait_snap(100, n);
    check("ovr_first_snap", 32'(n), 20);
    @(negedge clk);
    @(negedge clk);
    ready_mode = 2;
    @(negedge clk);
    tx_ready_i = 1'b0;
    repeat (25) @(negedge clk);
    check("ovr_flag_during_stall", 32'(overrun_o), 1);
    check("ovr_still_busy", 32'(busy_o), 1);
    repeat (25) @(negedge clk);
    exp_ovr = 3;
    tx_ready_i = 1'b1;
    ready_mode = 0;
    wait_snap(60, n);
    check("ovr_next_snap", 32'(n), 27);
    check("ovr_clear_without_snap", 32'(ovr_clr_seen), 3);
    check("ovr_sticky", 32'(overrun_o), 1);
    enable_i = 1'b0;
    drain("ovr");
    check("ovr_sticky_after_idle", 32'(overrun_o), 1);

    // Reset in the middle of the data phase
    period_i = 32'd50;
    enable_i = 1'b1;
    wait_snap(100, n);
    check("rst_snap_seen", 32'(n > 0), 1);
    n = 0;
    while (!(state_o == ST_DATA && word_idx_o == IW'(2)) && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("rst_reached_data", 32'(n < 100), 1);
    #2;
    reset_n = 1'b0;
    #1;
    check_reset_outputs("midframe_reset");
    repeat (3) @(negedge clk);
    exp_q.delete();
    seq_m = 0;
    exp_ovr = 0;
    enable_i = 1'b0;
    reset_n = 1'b1;
    quiet("post_reset", 40);
    check("post_reset_idle", 32'(state_o), 32'(ST_IDLE));

    // Random backpressure
    do_reset();
    data_mode = 0;
    ready_mode = 1;
    period_i = 32'd200;
    enable_i = 1'b1;
    wait_snap(300, n);
    check("bp_first_snap", 32'(n), 200);
    for (int f = 0; f < 3; f++) begin
      wait_snap(300, n);
      check($sformatf("bp_snap_%0d", f), 32'(n), 200);
    end
    enable_i = 1'b0;
    drain("bp");
    check("bp_no_overrun", 32'(overrun_o), 0);
    ready_mode = 0;

    // Clamped period, enable dropped mid-frame
    do_reset();
    data_mode = 1;
    period_i = 32'd3;
    enable_i = 1'b1;
    wait_snap(100, n);
    check("dis_snap", 32'(n), 16);
    repeat (4) @(negedge clk);
    check("dis_busy_mid_frame", 32'(busy_o), 1);
    enable_i = 1'b0;
    drain("dis");
    quiet("dis_after_frame", 40);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    errors++;
    $display("FAIL watchdog: time limit reached, got timeout expected completion");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog");
  end
endmodule
